// File: rtl/enemy_tiros_pkg.sv
// Shared screen, player and default enemy/bullet geometry for the enemy bullet block.
// Coordinates are handled in 12-bit unsigned so spawn and overlap sums never wrap.
package enemy_tiros_pkg;

    localparam int TELA_L    = 640;
    localparam int TELA_A    = 480;

    localparam int JOGADOR_Y = 440;
    localparam int JOGADOR_L = 32;
    localparam int JOGADOR_A = 16;

    localparam int DEF_LINHAS          = 4;
    localparam int DEF_COLUNAS         = 8;
    localparam int DEF_N_TIROS         = 4;
    localparam int DEF_ESP_X           = 32;
    localparam int DEF_ESP_Y           = 24;
    localparam int DEF_INIMIGO_L       = 16;
    localparam int DEF_INIMIGO_A       = 16;
    localparam int DEF_TIRO_L          = 2;
    localparam int DEF_TIRO_A          = 8;
    localparam int DEF_VEL             = 2;
    localparam int DEF_DISPARO_PERIODO = 50000000;
    localparam int DEF_MOVE_PERIODO    = 250000;

    typedef logic [11:0] coord_t;

    // Closed intervals [a_lo, a_hi] and [b_lo, b_hi] share at least one pixel.
    function automatic logic spans_overlap(input coord_t a_lo, input coord_t a_hi,
                                           input coord_t b_lo, input coord_t b_hi);
        return (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

endpackage

// File: rtl/enemy_tiros_if.sv
// Engine/renderer-facing bundle of the enemy bullet block.
interface enemy_tiros_if
    import enemy_tiros_pkg::*;
#(
    parameter int LINHAS  = DEF_LINHAS,
    parameter int COLUNAS = DEF_COLUNAS,
    parameter int N_TIROS = DEF_N_TIROS
);
    logic [5:0]                ID_enemy_tiro_X;
    logic [5:0]                ID_enemy_tiro_Y;
    logic [LINHAS*COLUNAS-1:0] enemy_vivos;
    logic [9:0]                grid_x;
    logic [9:0]                grid_y;
    logic [9:0]                jogador_x;
    logic [1:0]                estado_jogo;
    logic [N_TIROS-1:0]        tiro_ativo;
    logic [N_TIROS*10-1:0]     tiro_x;
    logic [N_TIROS*10-1:0]     tiro_y;
    logic                      jogador_vivo;
    logic                      jogador_atingido;

    modport master (
        output ID_enemy_tiro_X, ID_enemy_tiro_Y, enemy_vivos, grid_x, grid_y,
               jogador_x, estado_jogo,
        input  tiro_ativo, tiro_x, tiro_y, jogador_vivo, jogador_atingido
    );

    modport slave (
        input  ID_enemy_tiro_X, ID_enemy_tiro_Y, enemy_vivos, grid_x, grid_y,
               jogador_x, estado_jogo,
        output tiro_ativo, tiro_x, tiro_y, jogador_vivo, jogador_atingido
    );

endinterface

// File: rtl/enemy_tiros_tiro_slot.sv
// One enemy bullet slot: position registers, load/move/despawn and player overlap.
module tiro_slot
    import enemy_tiros_pkg::*;
#(
    parameter int TIRO_L = DEF_TIRO_L,
    parameter int TIRO_A = DEF_TIRO_A,
    parameter int VEL    = DEF_VEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       load,
    input  logic       move,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [9:0] jogador_x,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hit
);

    coord_t y_moved;
    logic   overlap;

    assign y_moved = coord_t'(y) + coord_t'(VEL);

    assign overlap =
        spans_overlap(coord_t'(x), coord_t'(x) + coord_t'(TIRO_L - 1),
                      coord_t'(jogador_x), coord_t'(jogador_x) + coord_t'(JOGADOR_L - 1)) &&
        spans_overlap(coord_t'(y), coord_t'(y) + coord_t'(TIRO_A - 1),
                      coord_t'(JOGADOR_Y), coord_t'(JOGADOR_Y + JOGADOR_A - 1));

    assign hit = active && overlap;

    // A hit clears the slot without moving it; a despawned slot keeps its last position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (restart) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (hit) begin
            active <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            x      <= load_x;
            y      <= load_y;
        end else if (move && active) begin
            if (y_moved >= coord_t'(TELA_A))
                active <= 1'b0;
            else
                y <= y_moved[9:0];
        end
    end

endmodule

// File: rtl/enemy_tiros.sv
// Enemy bullet manager: periodic spawn under the selected shooter, descent,
// bottom-edge despawn and player hit detection.
module enemy_tiros
    import enemy_tiros_pkg::*;
#(
    parameter int LINHAS          = DEF_LINHAS,
    parameter int COLUNAS         = DEF_COLUNAS,
    parameter int N_TIROS         = DEF_N_TIROS,
    parameter int ESP_X           = DEF_ESP_X,
    parameter int ESP_Y           = DEF_ESP_Y,
    parameter int INIMIGO_L       = DEF_INIMIGO_L,
    parameter int INIMIGO_A       = DEF_INIMIGO_A,
    parameter int TIRO_L          = DEF_TIRO_L,
    parameter int TIRO_A          = DEF_TIRO_A,
    parameter int VEL             = DEF_VEL,
    parameter int DISPARO_PERIODO = DEF_DISPARO_PERIODO,
    parameter int MOVE_PERIODO    = DEF_MOVE_PERIODO
) (
    input logic          clk,
    input logic          reset,
    input logic          restart,
    enemy_tiros_if.slave bus
);

    localparam int N_INIMIGOS = LINHAS * COLUNAS;
    localparam int DW = (DISPARO_PERIODO > 1) ? $clog2(DISPARO_PERIODO) : 1;
    localparam int MW = (MOVE_PERIODO > 1) ? $clog2(MOVE_PERIODO) : 1;
    localparam int SW = (N_TIROS > 1) ? $clog2(N_TIROS) : 1;

    logic [DW-1:0]      cnt_disparo;
    logic [MW-1:0]      cnt_move;
    logic               run, spawn_wrap, move_wrap;
    logic               jogador_vivo, jogador_atingido;
    logic [N_TIROS-1:0] active, hit, load;
    logic [9:0]         slot_x [N_TIROS];
    logic [9:0]         slot_y [N_TIROS];
    logic [15:0]        row_base, col;
    coord_t             spawn_x, spawn_y;
    logic               shooter_ok, pos_ok, spawn_ok, free_found;
    logic [SW-1:0]      free_idx;

    assign run        = (bus.estado_jogo == 2'd1) && jogador_vivo;
    assign spawn_wrap = run && (cnt_disparo == DW'(DISPARO_PERIODO - 1));
    assign move_wrap  = run && (cnt_move == MW'(MOVE_PERIODO - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_disparo <= '0;
            cnt_move    <= '0;
        end else if (restart) begin
            cnt_disparo <= '0;
            cnt_move    <= '0;
        end else if (run) begin
            cnt_disparo <= spawn_wrap ? '0 : cnt_disparo + 1'b1;
            cnt_move    <= move_wrap ? '0 : cnt_move + 1'b1;
        end
    end

    // The column is only meaningful when the linear index really falls in the given row.
    assign row_base   = 16'(bus.ID_enemy_tiro_Y) * 16'(COLUNAS);
    assign col        = 16'(bus.ID_enemy_tiro_X) - row_base;
    assign shooter_ok = (int'(bus.ID_enemy_tiro_X) < N_INIMIGOS) &&
                        (|(bus.enemy_vivos & (N_INIMIGOS'(1) << bus.ID_enemy_tiro_X))) &&
                        (int'(bus.ID_enemy_tiro_Y) < LINHAS) &&
                        (16'(bus.ID_enemy_tiro_X) >= row_base) &&
                        (col < 16'(COLUNAS));

    assign spawn_x = coord_t'(bus.grid_x) + coord_t'(col) * coord_t'(ESP_X)
                   + coord_t'((INIMIGO_L - TIRO_L) / 2);
    assign spawn_y = coord_t'(bus.grid_y) + coord_t'(bus.ID_enemy_tiro_Y) * coord_t'(ESP_Y)
                   + coord_t'(INIMIGO_A);
    assign pos_ok  = (spawn_x < coord_t'(TELA_L)) && (spawn_y < coord_t'(TELA_A));

    assign spawn_ok = spawn_wrap && shooter_ok && pos_ok && free_found;

    // Uses registered flags, so a slot freed this cycle is only reusable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_TIROS; i++) begin
            if (!active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    for (genvar g = 0; g < N_TIROS; g++) begin : g_slot
        assign load[g] = spawn_ok && (free_idx == SW'(g));

        tiro_slot #(
            .TIRO_L (TIRO_L),
            .TIRO_A (TIRO_A),
            .VEL    (VEL)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .restart   (restart),
            .load      (load[g]),
            .move      (move_wrap),
            .load_x    (spawn_x[9:0]),
            .load_y    (spawn_y[9:0]),
            .jogador_x (bus.jogador_x),
            .active    (active[g]),
            .x         (slot_x[g]),
            .y         (slot_y[g]),
            .hit       (hit[g])
        );

        assign bus.tiro_x[10*g +: 10] = slot_x[g];
        assign bus.tiro_y[10*g +: 10] = slot_y[g];
    end

    // Death is sticky; the pulse marks only the alive-to-dead transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jogador_vivo     <= 1'b1;
            jogador_atingido <= 1'b0;
        end else if (restart) begin
            jogador_vivo     <= 1'b1;
            jogador_atingido <= 1'b0;
        end else begin
            jogador_atingido <= jogador_vivo && (|hit);
            if (|hit)
                jogador_vivo <= 1'b0;
        end
    end

    assign bus.tiro_ativo       = active;
    assign bus.jogador_vivo     = jogador_vivo;
    assign bus.jogador_atingido = jogador_atingido;

endmodule

// File: tb/tb_enemy_tiros.sv
// Bench for enemy_tiros: directed scenarios plus randomized play against a
// pixel-level reference model of bullet spawning, descent and player hits.
module tb_enemy_tiros;

    localparam int DP = 4;
    localparam int MP = 2;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic reset;
    logic restart;

    enemy_tiros_if #(.LINHAS(4), .COLUNAS(8), .N_TIROS(NT)) bus ();

    enemy_tiros #(
        .LINHAS(4), .COLUNAS(8), .N_TIROS(NT),
        .DISPARO_PERIODO(DP), .MOVE_PERIODO(MP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_cd, m_cm;
    bit m_act [NT];
    int m_x   [NT];
    int m_y   [NT];
    bit m_vivo, m_ating;

    function automatic void model_clear();
        m_cd = 0; m_cm = 0; m_vivo = 1'b1; m_ating = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
    endfunction

    // One clock of game rules, evaluated on the inputs present before the edge.
    function automatic void model_step();
        bit run, mv, ok, any_hit;
        bit hits [NT];
        int slot, idx, row, col, sx, sy, jx;
        if (reset || restart) begin
            model_clear();
            return;
        end
        run = (bus.estado_jogo == 2'd1) && m_vivo;
        jx  = int'(bus.jogador_x);
        any_hit = 1'b0;
        for (int i = 0; i < NT; i++) begin
            hits[i] = m_act[i] && (m_x[i] <= jx + 31) && (m_x[i] + 1 >= jx) &&
                      (m_y[i] <= 455) && (m_y[i] + 7 >= 440);
            any_hit |= hits[i];
        end
        slot = -1;
        for (int i = 0; i < NT; i++)
            if (!m_act[i] && slot < 0) slot = i;
        idx = int'(bus.ID_enemy_tiro_X);
        row = int'(bus.ID_enemy_tiro_Y);
        col = idx - row * 8;
        sx  = int'(bus.grid_x) + col * 32 + 7;
        sy  = int'(bus.grid_y) + row * 24 + 16;
        ok  = run && (m_cd == DP - 1) && (idx < 32) && (row < 4) && (col >= 0) &&
              (col < 8) && (slot >= 0) && (sx < 640) && (sy < 480);
        if (ok) ok = bus.enemy_vivos[idx];
        mv = run && (m_cm == MP - 1);
        for (int i = 0; i < NT; i++) begin
            if (hits[i]) m_act[i] = 1'b0;
            else if (ok && slot == i) begin
                m_act[i] = 1'b1; m_x[i] = sx; m_y[i] = sy;
            end else if (mv && m_act[i]) begin
                if (m_y[i] + 2 >= 480) m_act[i] = 1'b0;
                else m_y[i] = m_y[i] + 2;
            end
        end
        m_ating = m_vivo && any_hit;
        m_vivo  = m_vivo && !any_hit;
        if (run) begin
            m_cd = (m_cd + 1) % DP;
            m_cm = (m_cm + 1) % MP;
        end
    endfunction

    function automatic logic [NT-1:0] exp_ativo();
        logic [NT-1:0] v;
        for (int i = 0; i < NT; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [NT*10-1:0] exp_x();
        logic [NT*10-1:0] v;
        for (int i = 0; i < NT; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [NT*10-1:0] exp_y();
        logic [NT*10-1:0] v;
        for (int i = 0; i < NT; i++) v[10*i +: 10] = 10'(m_y[i]);
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.grid_x = 10'd100; bus.grid_y = 10'd50;
        bus.ID_enemy_tiro_X = 6'd10; bus.ID_enemy_tiro_Y = 6'd1;
        bus.enemy_vivos = '1; bus.jogador_x = 10'd500; bus.estado_jogo = 2'd1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (8) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0011) begin
            n_fail++; $display("[TB] FAIL pre_reset_ativo got %b expected %b", bus.tiro_ativo, 4'b0011);
        end
        #2 reset = 1'b1;
        #1 model_clear();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL async_reset_ativo got %b expected 0000", bus.tiro_ativo);
        end
        n_cmp++;
        if (bus.jogador_vivo !== 1'b1) begin
            n_fail++; $display("[TB] FAIL async_reset_vivo got %b expected 1", bus.jogador_vivo);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL early_spawn got %b expected 0000", bus.tiro_ativo);
        end
        tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0001 || bus.tiro_y[9:0] !== 10'd90) begin
            n_fail++; $display("[TB] FAIL first_spawn_after_reset got ativo=%b y=%0d expected 0001 y=90",
                               bus.tiro_ativo, bus.tiro_y[9:0]);
        end
    endtask

    task automatic test_spawn_position();
        do_restart();
        set_defaults();
        repeat (3) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL spawn_before_wrap got %b expected 0000", bus.tiro_ativo);
        end
        tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0001 || bus.tiro_x[9:0] !== 10'd171 || bus.tiro_y[9:0] !== 10'd90) begin
            n_fail++; $display("[TB] FAIL spawn_pos_row1 got ativo=%b x=%0d y=%0d expected 0001 x=171 y=90",
                               bus.tiro_ativo, bus.tiro_x[9:0], bus.tiro_y[9:0]);
        end
        bus.grid_x = 10'd20; bus.grid_y = 10'd100;
        bus.ID_enemy_tiro_X = 6'd29; bus.ID_enemy_tiro_Y = 6'd3;
        repeat (4) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0011 || bus.tiro_x[19:10] !== 10'd187 || bus.tiro_y[19:10] !== 10'd188) begin
            n_fail++; $display("[TB] FAIL spawn_pos_row3 got ativo=%b x=%0d y=%0d expected 0011 x=187 y=188",
                               bus.tiro_ativo, bus.tiro_x[19:10], bus.tiro_y[19:10]);
        end
    endtask

    task automatic test_spawn_rejected();
        logic [31:0] vivos_10_dead;
        vivos_10_dead = '1;
        vivos_10_dead[10] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_restart();
            set_defaults();
            case (k)
                0: bus.enemy_vivos = vivos_10_dead;
                1: bus.ID_enemy_tiro_X = 6'd40;
                2: bus.ID_enemy_tiro_Y = 6'd2;
                3: bus.grid_x = 10'd600;
                default: bus.grid_y = 10'd440;
            endcase
            repeat (12) tick();
            n_cmp++;
            if (bus.tiro_ativo !== 4'b0000) begin
                n_fail++; $display("[TB] FAIL reject_case%0d got %b expected 0000", k, bus.tiro_ativo);
            end
        end
        do_restart();
        set_defaults();
        bus.grid_x = 10'd568;
        repeat (4) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b0001 || bus.tiro_x[9:0] !== 10'd639) begin
            n_fail++; $display("[TB] FAIL right_edge_spawn got ativo=%b x=%0d expected 0001 x=639",
                               bus.tiro_ativo, bus.tiro_x[9:0]);
        end
    endtask

    task automatic test_bottom_despawn();
        int guard;
        do_restart();
        set_defaults();
        guard = 0;
        while (!(m_act[0] && m_y[0] == 476) && guard < 1500) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 1500 || bus.tiro_ativo[0] !== 1'b1 || bus.tiro_y[9:0] !== 10'd476) begin
            n_fail++; $display("[TB] FAIL reach_476 got ativo0=%b y=%0d expected 1 y=476 (guard %0d)",
                               bus.tiro_ativo[0], bus.tiro_y[9:0], guard);
        end
        guard = 0;
        while (m_y[0] == 476 && guard < 4) begin tick(); guard++; end
        n_cmp++;
        if (bus.tiro_ativo[0] !== 1'b1 || bus.tiro_y[9:0] !== 10'd478) begin
            n_fail++; $display("[TB] FAIL move_to_478 got ativo0=%b y=%0d expected 1 y=478",
                               bus.tiro_ativo[0], bus.tiro_y[9:0]);
        end
        guard = 0;
        while (m_act[0] && guard < 4) begin tick(); guard++; end
        n_cmp++;
        if (bus.tiro_ativo[0] !== 1'b0 || bus.tiro_y[9:0] !== 10'd478) begin
            n_fail++; $display("[TB] FAIL despawn_480 got ativo0=%b y=%0d expected 0 y=478",
                               bus.tiro_ativo[0], bus.tiro_y[9:0]);
        end
    endtask

    task automatic test_player_hit();
        int guard, pulses;
        logic [NT*10-1:0] snap_y;
        logic [NT-1:0]    snap_a;
        do_restart();
        set_defaults();
        bus.jogador_x = 10'd160;
        guard = 0;
        while (!m_ating && guard < 1500) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 1500 || bus.jogador_atingido !== 1'b1 || bus.jogador_vivo !== 1'b0 ||
            bus.tiro_ativo[0] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL hit_event got ating=%b vivo=%b ativo0=%b expected 1 0 0 (guard %0d)",
                               bus.jogador_atingido, bus.jogador_vivo, bus.tiro_ativo[0], guard);
        end
        snap_y = exp_y();
        snap_a = exp_ativo();
        pulses = 0;
        repeat (20) begin
            tick();
            if (bus.jogador_atingido !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++; $display("[TB] FAIL hit_single_pulse got %0d extra pulses expected 0", pulses);
        end
        n_cmp++;
        if (bus.tiro_y !== snap_y || bus.tiro_ativo !== snap_a) begin
            n_fail++; $display("[TB] FAIL frozen_after_hit got ativo=%b y=%h expected ativo=%b y=%h",
                               bus.tiro_ativo, bus.tiro_y, snap_a, snap_y);
        end
        do_restart();
        n_cmp++;
        if (bus.jogador_vivo !== 1'b1 || bus.tiro_ativo !== 4'b0000 || bus.jogador_atingido !== 1'b0) begin
            n_fail++; $display("[TB] FAIL restart_after_hit got vivo=%b ativo=%b ating=%b expected 1 0000 0",
                               bus.jogador_vivo, bus.tiro_ativo, bus.jogador_atingido);
        end
    endtask

    task automatic test_full_and_pause();
        logic [NT*10-1:0] snap_y;
        do_restart();
        set_defaults();
        repeat (16) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b1111) begin
            n_fail++; $display("[TB] FAIL all_slots_full got %b expected 1111", bus.tiro_ativo);
        end
        repeat (4) tick();
        n_cmp++;
        if (bus.tiro_ativo !== 4'b1111 || bus.tiro_x !== exp_x() || bus.tiro_y !== exp_y()) begin
            n_fail++; $display("[TB] FAIL drop_when_full got ativo=%b y=%h expected 1111 y=%h",
                               bus.tiro_ativo, bus.tiro_y, exp_y());
        end
        bus.estado_jogo = 2'd2;
        snap_y = exp_y();
        repeat (20) tick();
        n_cmp++;
        if (bus.tiro_y !== snap_y || bus.tiro_ativo !== 4'b1111) begin
            n_fail++; $display("[TB] FAIL pause_freeze got y=%h expected y=%h", bus.tiro_y, snap_y);
        end
        bus.estado_jogo = 2'd1;
        repeat (4) tick();
        n_cmp++;
        if (bus.tiro_y[9:0] !== snap_y[9:0] + 10'd4) begin
            n_fail++; $display("[TB] FAIL resume_motion got y0=%0d expected %0d",
                               bus.tiro_y[9:0], snap_y[9:0] + 10'd4);
        end
    endtask

    task automatic test_random();
        int row;
        do_restart();
        for (int t = 0; t < 2000; t++) begin
            if (t % 16 == 0) begin
                bus.grid_x = 10'($urandom_range(0, 650));
                bus.grid_y = 10'($urandom_range(0, 460));
                row = $urandom_range(0, 4);
                bus.ID_enemy_tiro_Y = 6'(row);
                if ($urandom_range(0, 1) == 0) bus.ID_enemy_tiro_X = 6'(row * 8 + $urandom_range(0, 7));
                else bus.ID_enemy_tiro_X = 6'($urandom_range(0, 40));
                bus.enemy_vivos = $urandom | $urandom;
                bus.jogador_x = 10'($urandom_range(0, 639));
                bus.estado_jogo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            end
            restart = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++;
            if (bus.tiro_ativo !== exp_ativo()) begin
                n_fail++; $display("[TB] FAIL rand_ativo t=%0d got %b expected %b", t, bus.tiro_ativo, exp_ativo());
            end
            n_cmp++;
            if (bus.tiro_x !== exp_x()) begin
                n_fail++; $display("[TB] FAIL rand_x t=%0d got %h expected %h", t, bus.tiro_x, exp_x());
            end
            n_cmp++;
            if (bus.tiro_y !== exp_y()) begin
                n_fail++; $display("[TB] FAIL rand_y t=%0d got %h expected %h", t, bus.tiro_y, exp_y());
            end
            n_cmp++;
            if (bus.jogador_vivo !== m_vivo) begin
                n_fail++; $display("[TB] FAIL rand_vivo t=%0d got %b expected %b", t, bus.jogador_vivo, m_vivo);
            end
            n_cmp++;
            if (bus.jogador_atingido !== m_ating) begin
                n_fail++; $display("[TB] FAIL rand_atingido t=%0d got %b expected %b", t, bus.jogador_atingido, m_ating);
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        set_defaults();
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_spawn_position();
        test_spawn_rejected();
        test_bottom_despawn();
        test_player_hit();
        test_full_and_pause();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
